// File: rtl/aes_vector_sequencer_if.sv
// Signal bundle between aes_vector_sequencer, its host and the AES core under test.
// master: the sequencer's view; slave: the host/AES side.
interface aes_vector_sequencer_if #(
    parameter int DATA_W  = 128,
    parameter int NUM_VEC = 4
);
    localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

    logic              vec_wr_en;
    logic [AW-1:0]     vec_wr_addr;
    logic [DATA_W-1:0] vec_wr_pt;
    logic [DATA_W-1:0] vec_wr_key;
    logic [DATA_W-1:0] vec_wr_exp;
    logic              start;
    logic [AW:0]       run_len;
    logic              perturb_en;
    logic              AES_en;
    logic [DATA_W-1:0] AES_data_in;
    logic [DATA_W-1:0] AES_key_in;
    logic              AES_data_out_valid;
    logic [DATA_W-1:0] AES_data_out;
    logic              busy;
    logic              done;
    logic [AW:0]       pass_cnt;
    logic [AW:0]       fail_cnt;
    logic [AW-1:0]     first_fail_idx;
    logic              timeout_flag;
    logic              stable_err;

    modport master (
        input  vec_wr_en, vec_wr_addr, vec_wr_pt, vec_wr_key, vec_wr_exp,
        input  start, run_len, perturb_en,
        input  AES_data_out_valid, AES_data_out,
        output AES_en, AES_data_in, AES_key_in,
        output busy, done, pass_cnt, fail_cnt, first_fail_idx, timeout_flag, stable_err
    );

    modport slave (
        output vec_wr_en, vec_wr_addr, vec_wr_pt, vec_wr_key, vec_wr_exp,
        output start, run_len, perturb_en,
        output AES_data_out_valid, AES_data_out,
        input  AES_en, AES_data_in, AES_key_in,
        input  busy, done, pass_cnt, fail_cnt, first_fail_idx, timeout_flag, stable_err
    );
endinterface

// File: rtl/aes_vector_sequencer.sv
// Drives AES_top through a stored list of plaintext/key vectors and scores each
// result against its expected ciphertext, with hold, timeout and gap perturbation.
module aes_vector_sequencer #(
    parameter int DATA_W     = 128,
    parameter int NUM_VEC    = 4,
    parameter int EN_HOLD    = 51,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 3
) (
    input logic                    AES_clk,
    input logic                    AES_rst_n,
    aes_vector_sequencer_if.master bus
);
    localparam int AW    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int CW    = AW + 1;
    localparam int CYC_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [31:0]      LFSR_SEED    = 32'hACE1_0001;
    localparam logic [CW-1:0]    NUM_VEC_L    = CW'(NUM_VEC);
    localparam logic [CYC_W-1:0] HOLD_LAST    = CYC_W'(EN_HOLD - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RUN, WAIT, CHECK, GAP, DONE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] pt;
        logic [DATA_W-1:0] key;
        logic [DATA_W-1:0] exp;
    } vec_t;

    state_t            state;
    vec_t              mem [NUM_VEC];
    logic [CW-1:0]     idx;
    logic [CW-1:0]     run_len_q;
    logic [CYC_W-1:0]  cyc;
    logic [GAP_W-1:0]  gap_cnt;
    logic              got;
    logic              perturb_q;
    logic [DATA_W-1:0] cap;
    logic [31:0]       lfsr;

    logic              wr_ok;
    logic [CW-1:0]     idx_inc;
    logic [CW-1:0]     run_len_clamped;
    logic [DATA_W-1:0] cur_exp;
    logic [DATA_W-1:0] nxt_pt;
    logic [DATA_W-1:0] nxt_key;
    logic [DATA_W-1:0] first_pt;
    logic [DATA_W-1:0] first_key;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    assign wr_ok           = (state == IDLE) && bus.vec_wr_en;
    assign idx_inc         = idx + CW'(1);
    assign run_len_clamped = (bus.run_len > NUM_VEC_L) ? NUM_VEC_L : bus.run_len;
    assign cur_exp         = mem[idx[AW-1:0]].exp;
    assign nxt_pt          = mem[idx_inc[AW-1:0]].pt;
    assign nxt_key         = mem[idx_inc[AW-1:0]].key;

    // A write in the same cycle as start must be seen by vector 0.
    // NOTE: both outputs get a default before the override so no latch is inferred.
    always_comb begin
        first_pt  = mem[0].pt;
        first_key = mem[0].key;
        if (wr_ok && bus.vec_wr_addr == '0) begin
            first_pt  = bus.vec_wr_pt;
            first_key = bus.vec_wr_key;
        end
    end

    // NOTE: vector storage deliberately has no reset; the host loads it before
    // every run, so it behaves as a plain RAM.
    always_ff @(posedge AES_clk) begin
        if (wr_ok) begin
            mem[bus.vec_wr_addr] <= '{pt: bus.vec_wr_pt, key: bus.vec_wr_key, exp: bus.vec_wr_exp};
        end
    end

    // NOTE: every register here uses <= so all branches read start-of-cycle values.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state              <= IDLE;
            idx                <= '0;
            run_len_q          <= '0;
            cyc                <= '0;
            gap_cnt            <= '0;
            got                <= 1'b0;
            perturb_q          <= 1'b0;
            cap                <= '0;
            lfsr               <= LFSR_SEED;
            bus.AES_en         <= 1'b0;
            bus.AES_data_in    <= '0;
            bus.AES_key_in     <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.pass_cnt       <= '0;
            bus.fail_cnt       <= '0;
            bus.first_fail_idx <= '0;
            bus.timeout_flag   <= 1'b0;
            bus.stable_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.pass_cnt       <= '0;
                        bus.fail_cnt       <= '0;
                        bus.first_fail_idx <= '0;
                        bus.timeout_flag   <= 1'b0;
                        bus.stable_err     <= 1'b0;
                        bus.done           <= 1'b0;
                        bus.busy           <= 1'b1;
                        idx                <= '0;
                        lfsr               <= LFSR_SEED;
                        perturb_q          <= bus.perturb_en;
                        run_len_q          <= run_len_clamped;
                        cyc                <= '0;
                        got                <= 1'b0;
                        if (run_len_clamped == '0) begin
                            state <= DONE;
                        end else begin
                            state           <= RUN;
                            bus.AES_en      <= 1'b1;
                            bus.AES_data_in <= first_pt;
                            bus.AES_key_in  <= first_key;
                        end
                    end
                end

                RUN: begin
                    cyc <= cyc + CYC_W'(1);
                    if (bus.AES_data_out_valid && !got) begin
                        cap <= bus.AES_data_out;
                        got <= 1'b1;
                    end
                    if (cyc == HOLD_LAST) begin
                        bus.AES_en <= 1'b0;
                        state      <= (got || bus.AES_data_out_valid) ? CHECK : WAIT;
                    end
                end

                WAIT: begin
                    cyc <= cyc + CYC_W'(1);
                    if (bus.AES_data_out_valid) begin
                        cap   <= bus.AES_data_out;
                        got   <= 1'b1;
                        state <= CHECK;
                    end else if (cyc == TIMEOUT_LAST) begin
                        bus.timeout_flag <= 1'b1;
                        bus.fail_cnt     <= bus.fail_cnt + CW'(1);
                        if (bus.fail_cnt == '0) bus.first_fail_idx <= idx[AW-1:0];
                        state   <= GAP;
                        gap_cnt <= '0;
                        if (perturb_q) begin
                            bus.AES_data_in <= {(DATA_W/32){lfsr}};
                            lfsr            <= lfsr_next(lfsr);
                        end
                    end
                end

                CHECK: begin
                    if (cap == cur_exp) begin
                        bus.pass_cnt <= bus.pass_cnt + CW'(1);
                    end else begin
                        bus.fail_cnt <= bus.fail_cnt + CW'(1);
                        if (bus.fail_cnt == '0) bus.first_fail_idx <= idx[AW-1:0];
                    end
                    state   <= GAP;
                    gap_cnt <= '0;
                    if (perturb_q) begin
                        bus.AES_data_in <= {(DATA_W/32){lfsr}};
                        lfsr            <= lfsr_next(lfsr);
                    end
                end

                GAP: begin
                    if (got && bus.AES_data_out != cap) bus.stable_err <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        idx <= idx_inc;
                        if (idx_inc == run_len_q) begin
                            state <= DONE;
                        end else begin
                            state           <= RUN;
                            bus.AES_en      <= 1'b1;
                            bus.AES_data_in <= nxt_pt;
                            bus.AES_key_in  <= nxt_key;
                            cyc             <= '0;
                            got             <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                        if (perturb_q) begin
                            bus.AES_data_in <= {(DATA_W/32){lfsr}};
                            lfsr            <= lfsr_next(lfsr);
                        end
                    end
                end

                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
